taxi_axis_frame_gen: RTL and testbench

AXI4-Stream traffic source that emits frames of a programmed length carrying a deterministic incrementing-byte payload. It drives the sink side of stream blocks such as the AXI4-Stream register, FIFOs and adapters, in benches and in on-chip loopback/BIST paths. A paired checker consumes the same pattern at the far end. Configuration is latched on a start pulse; status reports busy, frames sent and completion.

---
 rtl/taxi_axis_gen_pkg.sv | 20 ++
 rtl/taxi_axis_if.sv | 34 +++
 rtl/taxi_axis_frame_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_taxi_axis_frame_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_axis_gen_pkg.sv
// Shared definitions for the AXI4-Stream frame generator and its companion checker.
// Holds the FSM state type, the payload pattern function and default counter widths.
package taxi_axis_gen_pkg;

    localparam int unsigned DEF_LEN_W = 16;
    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_GAP_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } gen_state_t;

    // Byte n of a frame whose byte 0 is seed; wraps mod 256.
    function automatic logic [7:0] next_byte(input logic [7:0] seed, input logic [7:0] n);
        return seed + n;
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle.
// Signals: tdata, tkeep, tvalid, tready, tlast, tid, tdest, tuser.
// Modports: src (drives stream, samples tready), snk (the reverse).
interface taxi_axis_if #(
    parameter int   DATA_W  = 8,
    parameter logic KEEP_EN = (DATA_W > 8),
    parameter int   KEEP_W  = (DATA_W + 7) / 8,
    parameter logic LAST_EN = 1'b1,
    parameter logic ID_EN   = 1'b0,
    parameter int   ID_W    = 8,
    parameter logic DEST_EN = 1'b0,
    parameter int   DEST_W  = 8,
    parameter logic USER_EN = 1'b0,
    parameter int   USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_axis_frame_gen.sv
// AXI4-Stream frame generator: emits frames of a programmed length carrying an
// incrementing-byte payload (byte n = seed_f + n, seed_f advancing by one per frame).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   m_axis              generated stream (all outputs registered)
//   start, stop         start latches config; stop ends the run after the current frame
//   cfg_len/count/gap   frame length (0 -> 1), frame count (0 = until stop), idle gap
//   cfg_seed/id/dest    first-frame byte 0, tid, tdest
//   busy, done          running flag, one-cycle pulse on return to idle
//   frames_sent         completed frames, saturating
module taxi_axis_frame_gen
    import taxi_axis_gen_pkg::*;
#(
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int ID_W   = 8,
    parameter int DEST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    taxi_axis_if.src          m_axis,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [GAP_W-1:0]  cfg_gap,
    input  logic [7:0]        cfg_seed,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [DEST_W-1:0] cfg_dest,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int   DATA_W      = m_axis.DATA_W;
    localparam int   KEEP_W      = m_axis.KEEP_W;
    localparam logic KEEP_EN     = m_axis.KEEP_EN;
    localparam logic LAST_EN     = m_axis.LAST_EN;
    localparam logic ID_EN       = m_axis.ID_EN;
    localparam int   AXIS_ID_W   = m_axis.ID_W;
    localparam logic DEST_EN     = m_axis.DEST_EN;
    localparam int   AXIS_DEST_W = m_axis.DEST_W;

    localparam logic [LEN_W-1:0] KEEP_W_L = LEN_W'(KEEP_W);
    localparam logic [7:0]       KEEP_W_B = 8'(KEEP_W);

    gen_state_t             state_q, state_d;
    logic                   tvalid_q, tvalid_d;
    logic [DATA_W-1:0]      tdata_q, tdata_d;
    logic [KEEP_W-1:0]      tkeep_q, tkeep_d;
    logic                   last_q, last_d;
    logic [AXIS_ID_W-1:0]   tid_q, tid_d;
    logic [AXIS_DEST_W-1:0] tdest_q, tdest_d;
    logic                   done_q, done_d;
    logic [CNT_W-1:0]       frames_q, frames_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [7:0]             seed_q, seed_d;
    // Bytes remaining in the frame, counting the beat currently presented.
    logic [LEN_W-1:0]       left_q, left_d;
    logic                   stop_q, stop_d;

    logic             hs;
    logic             ld;
    logic [7:0]       ld_base;
    logic [LEN_W-1:0] ld_left;
    logic [LEN_W-1:0] len_eff;
    logic [CNT_W-1:0] frames_inc;
    logic             stop_now;
    logic             count_hit;

    always_comb begin
        state_d   = state_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        last_d    = last_q;
        tid_d     = tid_q;
        tdest_d   = tdest_q;
        done_d    = 1'b0;
        frames_d  = frames_q;
        len_d     = len_q;
        count_d   = count_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        seed_d    = seed_q;
        left_d    = left_q;
        stop_d    = stop_q;

        ld      = 1'b0;
        ld_base = seed_q;
        ld_left = len_q;

        hs         = tvalid_q && m_axis.tready;
        len_eff    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        frames_inc = (&frames_q) ? frames_q : frames_q + CNT_W'(1);
        stop_now   = stop_q || stop;
        count_hit  = (count_q != '0) && (frames_inc == count_q);

        unique case (state_q)
            StIdle: begin
                // start wins over a simultaneous stop, which is simply dropped
                if (start) begin
                    state_d  = StSend;
                    tvalid_d = 1'b1;
                    frames_d = '0;
                    stop_d   = 1'b0;
                    len_d    = len_eff;
                    count_d  = cfg_count;
                    gap_d    = cfg_gap;
                    seed_d   = cfg_seed;
                    tid_d    = ID_EN ? AXIS_ID_W'(cfg_id) : '0;
                    tdest_d  = DEST_EN ? AXIS_DEST_W'(cfg_dest) : '0;
                    ld       = 1'b1;
                    ld_base  = cfg_seed;
                    ld_left  = len_eff;
                end
            end
            StSend: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (hs) begin
                    if (!last_q) begin
                        ld      = 1'b1;
                        // lane 0 of the current beat is the running byte base
                        ld_base = tdata_q[7:0] + KEEP_W_B;
                        ld_left = left_q - KEEP_W_L;
                    end else begin
                        frames_d = frames_inc;
                        seed_d   = seed_q + 8'd1;
                        if (stop_now || count_hit) begin
                            state_d  = StIdle;
                            tvalid_d = 1'b0;
                            done_d   = 1'b1;
                            stop_d   = 1'b0;
                        end else if (gap_q == '0) begin
                            ld      = 1'b1;
                            ld_base = seed_q + 8'd1;
                            ld_left = len_q;
                        end else begin
                            state_d   = StGap;
                            tvalid_d  = 1'b0;
                            gap_cnt_d = gap_q - GAP_W'(1);
                        end
                    end
                end
            end
            StGap: begin
                if (stop_now) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    stop_d  = 1'b0;
                end else if (gap_cnt_q == '0) begin
                    state_d  = StSend;
                    tvalid_d = 1'b1;
                    ld       = 1'b1;
                    ld_base  = seed_q;
                    ld_left  = len_q;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                tvalid_d = 1'b0;
            end
        endcase

        if (ld) begin
            left_d = ld_left;
            last_d = (ld_left <= KEEP_W_L);
            for (int k = 0; k < KEEP_W; k++) begin
                // lanes past the frame end carry pattern bytes as padding
                tdata_d[k*8 +: 8] = next_byte(ld_base, 8'(k));
                tkeep_d[k]        = KEEP_EN ? (LEN_W'(k) < ld_left) : 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            last_q    <= 1'b0;
            tid_q     <= '0;
            tdest_q   <= '0;
            done_q    <= 1'b0;
            frames_q  <= '0;
            len_q     <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            seed_q    <= '0;
            left_q    <= '0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            last_q    <= last_d;
            tid_q     <= tid_d;
            tdest_q   <= tdest_d;
            done_q    <= done_d;
            frames_q  <= frames_d;
            len_q     <= len_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            seed_q    <= seed_d;
            left_q    <= left_d;
            stop_q    <= stop_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = LAST_EN ? last_q : 1'b0;
    assign m_axis.tid    = tid_q;
    assign m_axis.tdest  = tdest_q;
    assign m_axis.tuser  = '0;

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_taxi_axis_frame_gen.sv
// Bench for taxi_axis_frame_gen: an 8-bit instance (tid/tdest enabled) and a 32-bit
// instance (tkeep enabled) driven from a table of runs, plus reset sequences.
module tb_taxi_axis_frame_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel;   // 1 selects the 32-bit instance
    logic        rdy;
    logic        start;
    logic        stop;
    logic [15:0] cfg_len;
    logic [31:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [7:0]  cfg_seed;
    logic [7:0]  cfg_id;
    logic [7:0]  cfg_dest;
    logic        busy8, done8, busy32, done32;
    logic [31:0] fs8, fs32;

    taxi_axis_if #(.DATA_W(8), .ID_EN(1'b1), .DEST_EN(1'b1)) ax8 ();
    taxi_axis_if #(.DATA_W(32)) ax32 ();

    assign ax8.tready  = !sel && rdy;
    assign ax32.tready = sel && rdy;

    taxi_axis_frame_gen dut8 (
        .clk(clk), .rst(rst), .m_axis(ax8),
        .start(start && !sel), .stop(stop && !sel),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
        .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .busy(busy8), .done(done8), .frames_sent(fs8)
    );

    taxi_axis_frame_gen dut32 (
        .clk(clk), .rst(rst), .m_axis(ax32),
        .start(start && sel), .stop(stop && sel),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
        .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .busy(busy32), .done(done32), .frames_sent(fs32)
    );

    logic        o_valid, o_last, o_busy, o_done;
    logic [31:0] o_data, o_fs;
    logic [3:0]  o_keep;
    logic [7:0]  o_id, o_dest;

    always_comb begin
        if (sel) begin
            o_valid = ax32.tvalid;
            o_data  = ax32.tdata;
            o_keep  = ax32.tkeep;
            o_last  = ax32.tlast;
            o_id    = ax32.tid;
            o_dest  = ax32.tdest;
            o_busy  = busy32;
            o_done  = done32;
            o_fs    = fs32;
        end else begin
            o_valid = ax8.tvalid;
            o_data  = {24'h0, ax8.tdata};
            o_keep  = {3'b0, ax8.tkeep};
            o_last  = ax8.tlast;
            o_id    = ax8.tid;
            o_dest  = ax8.tdest;
            o_busy  = busy8;
            o_done  = done8;
            o_fs    = fs8;
        end
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic sel;
        int   len;
        int   count;
        int   gap;
        int   seed;
        logic rnd;
        int   stop_frame;       // 1-based frame during which stop is pulsed, 0 = never
        logic stop_with_start;
        int   exp_frames;
        int   exp_beats;
        int   exp_last_keep;    // -1 = not checked
        int   exp_f1;           // byte 0 of the second frame, -1 = not checked
        int   exp_gap;          // idle cycles between frames, -1 = not checked
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic run_vec(input vec_t v);
        int w, len_eff, bpf, f, b, beats, idle, gmin, gmax, last_keep, f1, last_hs, cyc, n;
        logic seen_done, in_gap, stall, r;
        logic [31:0] p_data, exp_w, mask;
        logic [3:0]  p_keep, exp_k;
        logic        p_last;
        logic [7:0]  sf;

        w       = v.sel ? 4 : 1;
        len_eff = (v.len == 0) ? 1 : v.len;
        bpf     = (len_eff + w - 1) / w;

        @(negedge clk);
        sel       = v.sel;
        rdy       = 1'b1;
        cfg_len   = 16'(v.len);
        cfg_count = 32'(v.count);
        cfg_gap   = 8'(v.gap);
        cfg_seed  = 8'(v.seed);
        start     = 1'b1;
        stop      = v.stop_with_start;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("first_beat_valid", o_valid, 1);
        check("busy_after_start", o_busy, 1);

        f = 0; b = 0; beats = 0; idle = 0; gmin = 1000000; gmax = -1;
        last_keep = -1; f1 = -1; last_hs = 0; cyc = 0;
        seen_done = 1'b0; in_gap = 1'b0; stall = 1'b0;
        p_data = '0; p_keep = '0; p_last = 1'b0;

        while (!seen_done && cyc < 20000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            stop = 1'b0;
            if (o_done) begin
                seen_done = 1'b1;
                check("done_delay", 64'(cyc - last_hs), 1);
                check("busy_at_done", o_busy, 0);
                check("frames_sent", o_fs, 64'(v.exp_frames));
            end else begin
                if (stall) begin
                    check("stable_data", o_data, p_data);
                    check("stable_keep", o_keep, p_keep);
                    check("stable_last", o_last, p_last);
                end
                if (o_valid) begin
                    if (in_gap) begin
                        if (idle < gmin) gmin = idle;
                        if (idle > gmax) gmax = idle;
                    end
                    in_gap = 1'b0;
                end else if (in_gap) begin
                    idle++;
                end
                r      = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                rdy    = r;
                stall  = o_valid && !r;
                p_data = o_data;
                p_keep = o_keep;
                p_last = o_last;
                if (o_valid && r) begin
                    sf    = 8'(v.seed + f);
                    exp_w = '0;
                    mask  = '0;
                    exp_k = '0;
                    for (int k = 0; k < w; k++) begin
                        n = b * w + k;
                        if (n < len_eff) begin
                            exp_w[k*8 +: 8] = sf + 8'(n);
                            mask[k*8 +: 8]  = 8'hFF;
                            exp_k[k]        = 1'b1;
                        end
                    end
                    check("payload", o_data & mask, exp_w);
                    check("tlast", o_last, (b == bpf - 1) ? 1 : 0);
                    if (v.sel) check("tkeep", o_keep, exp_k);
                    check("tid", o_id, v.sel ? 8'h00 : 8'h5A);
                    check("tdest", o_dest, v.sel ? 8'h00 : 8'hA5);
                    if (f == 1 && b == 0) f1 = int'(o_data[7:0]);
                    if (v.stop_frame != 0 && f == v.stop_frame - 1 && b == 0) stop = 1'b1;
                    beats++;
                    if (b == bpf - 1) begin
                        last_keep = int'(o_keep);
                        f++;
                        b       = 0;
                        in_gap  = 1'b1;
                        idle    = 0;
                        last_hs = cyc;
                    end else begin
                        b++;
                    end
                end
            end
        end
        rdy = 1'b1;
        if (!seen_done) check("done_timeout", 0, 1);
        check("frames_seen", 64'(f), 64'(v.exp_frames));
        check("beats_seen", 64'(beats), 64'(v.exp_beats));
        if (v.exp_last_keep >= 0) check("last_keep", 64'(last_keep), 64'(v.exp_last_keep));
        if (v.exp_f1 >= 0) check("frame1_byte0", 64'(f1), 64'(v.exp_f1));
        if (v.exp_gap >= 0) begin
            check("gap_min", 64'(gmin), 64'(v.exp_gap));
            check("gap_max", 64'(gmax), 64'(v.exp_gap));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b1; rdy = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_len = '0; cfg_count = '0; cfg_gap = '0; cfg_seed = '0;
        cfg_id = 8'h5A; cfg_dest = 8'hA5;

        // sel len count gap seed rnd stopf sws | frames beats lkeep f1 gap
        vecs[0]  = '{1'b0, 4, 1, 0, 8'h10, 1'b0, 0, 1'b0, 1, 4, -1, -1, -1};
        vecs[1]  = '{1'b1, 6, 2, 0, 8'hFE, 1'b0, 0, 1'b0, 2, 4, 3, 8'hFF, 0};
        vecs[2]  = '{1'b0, 3, 3, 2, 8'h20, 1'b0, 0, 1'b0, 3, 9, -1, 8'h21, 2};
        vecs[3]  = '{1'b0, 3, 3, 0, 8'h20, 1'b0, 0, 1'b0, 3, 9, -1, 8'h21, 0};
        vecs[4]  = '{1'b1, 17, 1, 0, 8'h40, 1'b1, 0, 1'b0, 1, 5, 1, -1, -1};
        vecs[5]  = '{1'b0, 5, 0, 1, 8'h00, 1'b0, 3, 1'b0, 3, 15, -1, 8'h01, 1};
        vecs[6]  = '{1'b1, 0, 1, 0, 8'h07, 1'b0, 0, 1'b0, 1, 1, 1, -1, -1};
        vecs[7]  = '{1'b1, 8, 1, 0, 8'hFC, 1'b0, 0, 1'b0, 1, 2, 15, -1, -1};
        vecs[8]  = '{1'b0, 2, 2, 0, 8'h80, 1'b0, 0, 1'b1, 2, 4, -1, 8'h81, 0};
        vecs[9]  = '{1'b1, 6, 3, 3, 8'hFF, 1'b1, 0, 1'b0, 3, 6, 3, 8'h00, -1};
        vecs[10] = '{1'b1, 65535, 1, 0, 8'h00, 1'b0, 0, 1'b0, 1, 16384, 7, -1, -1};

        #1;
        check("rst_tvalid", o_valid, 0);
        check("rst_tdata", o_data, 0);
        check("rst_tkeep", o_keep, 0);
        check("rst_tlast", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_frames", o_fs, 0);
        sel = 1'b0;
        #1;
        check("rst_tid", o_id, 0);
        check("rst_tdest", o_dest, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of an unbounded run.
        @(negedge clk);
        sel = 1'b1; rdy = 1'b1;
        cfg_len = 16'd100; cfg_count = '0; cfg_gap = '0; cfg_seed = 8'h90;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", o_valid, 1);
        check("pre_rst_busy", o_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tvalid", o_valid, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_tdata", o_data, 0);
        check("mid_rst_frames", o_fs, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{1'b1, 4, 1, 0, 8'h33, 1'b0, 0, 1'b0, 1, 1, 15, -1, -1});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
